// File: rtl/qmult_rr_sched.sv
// Shared sequential sign-magnitude Q-format multiplier with a round-robin front end.
// One magnitude bit is consumed per cycle; results come back tagged with the owning requester.
module qmult_rr_sched #(
   parameter int Q    = 15,
   parameter int N    = 32,
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IW-1:0]     rsp_id,
   output logic [N-1:0]      rsp_result,
   output logic              rsp_ovf
);
   localparam int MW = N - 1;
   localparam int AW = 2 * N - 2;
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_FIN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   mcand_q, mcand_d;
   logic [MW-1:0]   mplier_q, mplier_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic            sign_q, sign_d;
   logic [IW-1:0]   id_q, id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IW-1:0]   rsp_id_q, rsp_id_d;
   logic [N-1:0]    rsp_result_q, rsp_result_d;
   logic            rsp_ovf_q, rsp_ovf_d;

   logic            gnt_found_s;
   logic [IW-1:0]   gnt_idx_s;
   logic [IW-1:0]   cand_s;
   logic            hs_s;
   logic [N-1:0]    a_sel_s, b_sel_s;
   logic [N:0]      fin_s;

   // Truncate the product to Q format and saturate; returns {ovf, sign, magnitude}.
   function automatic logic [N:0] fin_round(input logic [AW-1:0] acc, input logic sign);
      logic [AW-1:0] shifted;
      logic [MW-1:0] mag;
      logic          ovf;
      shifted = acc >> Q;
      if (|shifted[AW-1:MW]) begin
         mag = {MW{1'b1}};
         ovf = 1'b1;
      end else begin
         mag = shifted[MW-1:0];
         ovf = 1'b0;
      end
      return {ovf, sign & (|mag), mag};
   endfunction

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = {IW{1'b0}};
      cand_s      = {IW{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = IW'((int'(ptr_q) + k) % NREQ);
         if (!gnt_found_s && req_valid[cand_s]) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = cand_s;
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // One-hot grant, only offered while idle.
   always_comb begin
      req_ready = {NREQ{1'b0}};
      if (state_q == S_IDLE && gnt_found_s) begin
         req_ready[gnt_idx_s] = 1'b1;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   assign hs_s    = (state_q == S_IDLE) && gnt_found_s;
   assign a_sel_s = req_a[int'(gnt_idx_s) * N +: N];
   assign b_sel_s = req_b[int'(gnt_idx_s) * N +: N];
   assign fin_s   = fin_round(acc_q, sign_q);

   // Next-state and datapath update for the multiply sequence.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      acc_d        = acc_q;
      sign_d       = sign_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_ovf_d    = rsp_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (hs_s) begin
               mcand_d  = {{(AW - MW){1'b0}}, a_sel_s[MW-1:0]};
               mplier_d = b_sel_s[MW-1:0];
               sign_d   = a_sel_s[N-1] ^ b_sel_s[N-1];
               id_d     = gnt_idx_s;
               ptr_d    = gnt_idx_s;
               cnt_d    = CW'(N - 1);
               acc_d    = {AW{1'b0}};
               state_d  = S_MUL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end else begin
               acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FIN;
            end else begin
               state_d = S_MUL;
            end
         end
         S_FIN: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id_q;
            rsp_result_d = fin_s[N-1:0];
            rsp_ovf_d    = fin_s[N];
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= IW'(NREQ - 1);
         cnt_q        <= {CW{1'b0}};
         mcand_q      <= {AW{1'b0}};
         mplier_q     <= {MW{1'b0}};
         acc_q        <= {AW{1'b0}};
         sign_q       <= 1'b0;
         id_q         <= {IW{1'b0}};
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= {IW{1'b0}};
         rsp_result_q <= {N{1'b0}};
         rsp_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         acc_q        <= acc_d;
         sign_q       <= sign_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_ovf_q    <= rsp_ovf_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_ovf    = rsp_ovf_q;

endmodule

// File: tb/tb_qmult_rr_sched.sv
// Directed bench for qmult_rr_sched: product table, backpressure, fairness and mid-op reset.
module tb_qmult_rr_sched;
   logic          clk;
   logic          rst;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [127:0]  req_a;
   logic [127:0]  req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_result;
   logic          rsp_ovf;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   vec_t        vecs[10];
   logic [31:0] exp_fair[4];

   qmult_rr_sched #(.Q(15), .N(32), .NREQ(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ovf    (rsp_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after the accepting edge; returns edges until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   initial begin
      int lat;
      int acc_t[5];
      logic [3:0] onehot;

      vecs[0] = '{2'd0, 32'h0001_8000, 32'h8001_0000, 32'h8003_0000, 1'b0};
      vecs[1] = '{2'd1, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1};
      vecs[2] = '{2'd2, 32'hC000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b1};
      vecs[3] = '{2'd3, 32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0};
      vecs[4] = '{2'd0, 32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0};
      vecs[5] = '{2'd1, 32'h0000_4000, 32'h0000_4000, 32'h0000_2000, 1'b0};
      vecs[6] = '{2'd2, 32'h8001_8000, 32'h8001_0000, 32'h0003_0000, 1'b0};
      vecs[7] = '{2'd3, 32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0};
      vecs[8] = '{2'd0, 32'h7FFF_FFFF, 32'h0000_8001, 32'h7FFF_FFFF, 1'b1};
      vecs[9] = '{2'd1, 32'h8000_0001, 32'h0000_8000, 32'h8000_0001, 1'b0};
      exp_fair[0] = 32'h0001_0000;
      exp_fair[1] = 32'h0002_0000;
      exp_fair[2] = 32'h0003_0000;
      exp_fair[3] = 32'h0004_0000;

      rst       = 1'b1;
      req_valid = 4'b0000;
      req_a     = 128'd0;
      req_b     = 128'd0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_id", rsp_id, 2'd0);
      check("reset_rsp_result", rsp_result, 32'd0);
      check("reset_rsp_ovf", rsp_ovf, 1'b0);
      check("reset_req_ready", req_ready, 4'b0000);

      // Product table, one requester at a time
      for (int i = 0; i < 10; i++) begin
         req_a[vecs[i].id * 32 +: 32] = vecs[i].a;
         req_b[vecs[i].id * 32 +: 32] = vecs[i].b;
         onehot = 4'b0001 << vecs[i].id;
         req_valid = onehot;
         #1;
         check($sformatf("v%0d_req_ready", i), req_ready, onehot);
         @(posedge clk);
         #1 req_valid = 4'b0000;
         wait_rsp(lat);
         check($sformatf("v%0d_latency", i), lat, 32);
         check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
         check($sformatf("v%0d_ovf", i), rsp_ovf, vecs[i].ovf);
         check($sformatf("v%0d_id", i), rsp_id, vecs[i].id);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d_released", i), rsp_valid, 1'b0);
      end

      // Backpressure: hold the response for 10 cycles while req3 waits
      rsp_ready = 1'b0;
      req_a[32 +: 32] = 32'h0001_8000;
      req_b[32 +: 32] = 32'h0001_0000;
      req_valid = 4'b0010;
      @(posedge clk);
      #1 req_valid = 4'b1000;
      wait_rsp(lat);
      check("bp_latency", lat, 32);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp%0d_valid", k), rsp_valid, 1'b1);
         check($sformatf("bp%0d_result", k), rsp_result, 32'h0003_0000);
         check($sformatf("bp%0d_id", k), rsp_id, 2'd1);
         check($sformatf("bp%0d_ovf", k), rsp_ovf, 1'b0);
         check($sformatf("bp%0d_req_ready", k), req_ready, 4'b0000);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_valid", rsp_valid, 1'b0);
      check("bp_release_grant", req_ready, 4'b1000);
      req_valid = 4'b0000;

      // Fairness: all requesters valid straight out of reset
      rst = 1'b1;
      for (int r = 0; r < 4; r++) begin
         req_a[r * 32 +: 32] = 32'h0000_8000 * (r + 1);
         req_b[r * 32 +: 32] = 32'h0001_0000;
      end
      req_valid = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         #1;
         check($sformatf("fair%0d_grant", g), req_ready, 4'b0001 << (g % 4));
         acc_t[g] = cyc;
         if (g > 0) begin
            check($sformatf("fair%0d_spacing", g), acc_t[g] - acc_t[g-1], 34);
         end
         @(posedge clk);
         wait_rsp(lat);
         check($sformatf("fair%0d_id", g), rsp_id, g % 4);
         check($sformatf("fair%0d_result", g), rsp_result, exp_fair[g % 4]);
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = 4'b0000;

      // Reset ten cycles into a multiply for req2
      req_a[64 +: 32] = 32'h0004_0000;
      req_b[64 +: 32] = 32'h0000_8000;
      req_valid = 4'b0100;
      #1;
      check("rst_req2_grant", req_ready, 4'b0100);
      @(posedge clk);
      #1 req_valid = 4'b0000;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      req_valid = 4'b0101;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_valid", rsp_valid, 1'b0);
      check("rst_mid_grant", req_ready, 4'b0001);
      @(posedge clk);
      #1 req_valid = 4'b0000;
      wait_rsp(lat);
      check("rst_next_latency", lat, 32);
      check("rst_next_id", rsp_id, 2'd0);
      check("rst_next_result", rsp_result, 32'h0001_0000);
      @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
